cpu_stage_sequencer: RTL and testbench

- Multi-cycle stage sequencer for the CPU. It generates the fetch / getRegs / readMem / writeBack strobes that the control unit decodes.
- Stalls any stage that issued a memory access until the memory controller drops busy.
- Latches edge-triggered interrupt requests and injects a one-cycle interrupt-take stage between instructions.
- Counts retired instructions. Generalises the fixed-timing stage generator to a variable memory latency and NUM_IRQ prioritised interrupt channels.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_stage_sequencer_irq_edge_latch.sv | 66 ++++++
 rtl/cpu_stage_sequencer.sv | 124 ++++++++++++
 tb/tb_cpu_stage_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer stage encoding, opcodes used by the control
// unit, and a helper that sizes interrupt index fields.
package cpu_pkg;

    // One-hot so each stage strobe is a single flop output.
    typedef enum logic [4:0] {
        S_FETCH     = 5'b00001,
        S_GETREGS   = 5'b00010,
        S_READMEM   = 5'b00100,
        S_WRITEBACK = 5'b01000,
        S_INTTAKE   = 5'b10000
    } stage_e;

    typedef enum logic [4:0] {
        OP_NOP   = 5'h00,
        OP_LOAD  = 5'h01,
        OP_STORE = 5'h02,
        OP_MOV   = 5'h03,
        OP_ADD   = 5'h04,
        OP_SUB   = 5'h05,
        OP_AND   = 5'h06,
        OP_OR    = 5'h07,
        OP_XOR   = 5'h08,
        OP_SHL   = 5'h09,
        OP_SHR   = 5'h0a,
        OP_CMP   = 5'h0b,
        OP_JMP   = 5'h0c,
        OP_JZ    = 5'h0d,
        OP_JNZ   = 5'h0e,
        OP_CALL  = 5'h0f,
        OP_RET   = 5'h10,
        OP_RETI  = 5'h11,
        OP_EI    = 5'h12,
        OP_DI    = 5'h13,
        OP_HALT  = 5'h1f
    } opcode_e;

    // Index width for n channels; a single channel still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_stage_sequencer_irq_edge_latch.sv
// Interrupt front end: per-line synchroniser and rising-edge detect, pending
// latch where a new edge beats a same-cycle service clear, lowest-index pick.
module irq_edge_latch
    import cpu_pkg::*;
#(
    parameter  int NUM_IRQ = 4,
    localparam int ID_W    = id_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               clr_en,
    output logic [NUM_IRQ-1:0] pending,
    output logic               any_pending,
    output logic [ID_W-1:0]    int_id
);

    logic [NUM_IRQ-1:0] sync0_q, sync0_d;
    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [ID_W-1:0]    pick;

    // NOTE: defaults are assigned before any conditional logic so no path leaves a latch.
    always_comb begin
        sync0_d  = irq;
        sync1_d  = sync0_q;
        prev_d   = sync1_q;
        rise     = sync1_q & ~prev_q;
        pick     = '0;
        clr_mask = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_mask[i] = clr_en && (pick == ID_W'(i));
        end
        // Set after clear: an edge landing on the service cycle is not lost.
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    // NOTE: non-blocking assignments so each flop sees its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending     = pending_q;
    assign any_pending = |pending_q;
    assign int_id      = pick;

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle CPU stage sequencer: fetch/getRegs/readMem/writeBack strobes,
// memory-busy stalls, interrupt-take injection and retired-instruction count.
module cpu_stage_sequencer
    import cpu_pkg::*;
#(
    parameter  int          ADDR_WIDTH      = 27,
    parameter  int          NUM_IRQ         = 4,
    parameter  int unsigned IRQ_VECTOR_BASE = 1,
    parameter  int          CNT_WIDTH       = 32,
    localparam int          ID_W            = id_width(NUM_IRQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_start,
    input  logic                  mem_busy,
    input  logic                  reti,
    input  logic [NUM_IRQ-1:0]    irq,
    output logic                  fetch,
    output logic                  get_regs,
    output logic                  read_mem,
    output logic                  write_back,
    output logic                  int_take,
    output logic [ADDR_WIDTH-1:0] int_vector,
    output logic [ID_W-1:0]       int_id,
    output logic                  int_active,
    output logic [NUM_IRQ-1:0]    irq_pending,
    output logic [CNT_WIDTH-1:0]  instret
);

    stage_e               state_q, state_d;
    logic                 wait_q, wait_d;
    logic                 int_active_q, int_active_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic                 stage_done;
    logic                 any_pending;
    logic                 clr_en;

    irq_edge_latch #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .clr_en      (clr_en),
        .pending     (irq_pending),
        .any_pending (any_pending),
        .int_id      (int_id)
    );

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        int_active_d = int_active_q;
        instret_d    = instret_q;
        stage_done   = 1'b0;

        // Memory stages: first cycle may issue; afterwards wait out busy.
        unique case (state_q)
            S_FETCH, S_READMEM, S_WRITEBACK: begin
                if (!wait_q) begin
                    if (mem_start) begin
                        wait_d = 1'b1;
                    end else begin
                        stage_done = 1'b1;
                    end
                end else if (!mem_busy) begin
                    wait_d     = 1'b0;
                    stage_done = 1'b1;
                end
            end
            default: stage_done = 1'b1;
        endcase

        if (stage_done) begin
            unique case (state_q)
                S_FETCH:   state_d = S_GETREGS;
                S_GETREGS: state_d = S_READMEM;
                S_READMEM: state_d = S_WRITEBACK;
                S_WRITEBACK: begin
                    instret_d = instret_q + CNT_WIDTH'(1);
                    // RETI closes the handler; this boundary skips the interrupt check.
                    if (reti) begin
                        int_active_d = 1'b0;
                        state_d      = S_FETCH;
                    end else if (any_pending && !int_active_q) begin
                        state_d = S_INTTAKE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_INTTAKE: begin
                    int_active_d = 1'b1;
                    state_d      = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            wait_q       <= 1'b0;
            int_active_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            int_active_q <= int_active_d;
            instret_q    <= instret_d;
        end
    end

    assign clr_en     = (state_q == S_INTTAKE);
    assign fetch      = (state_q == S_FETCH);
    assign get_regs   = (state_q == S_GETREGS);
    assign read_mem   = (state_q == S_READMEM);
    assign write_back = (state_q == S_WRITEBACK);
    assign int_take   = (state_q == S_INTTAKE);
    assign int_active = int_active_q;
    assign instret    = instret_q;
    assign int_vector = ADDR_WIDTH'(IRQ_VECTOR_BASE) + ADDR_WIDTH'(int_id);

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench for cpu_stage_sequencer: vector table, hand-built
// interrupt/reset sequences, then random traffic against a behavioural model.
module tb_cpu_stage_sequencer;

    localparam int ADDR_WIDTH = 27;
    localparam int NUM_IRQ    = 4;
    localparam int CNT_WIDTH  = 32;

    localparam bit [4:0] ST_F = 5'b00001;
    localparam bit [4:0] ST_G = 5'b00010;
    localparam bit [4:0] ST_R = 5'b00100;
    localparam bit [4:0] ST_W = 5'b01000;
    localparam bit [4:0] ST_I = 5'b10000;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  mem_start, mem_busy, reti;
    logic [NUM_IRQ-1:0]    irq;
    logic                  fetch, get_regs, read_mem, write_back, int_take;
    logic [ADDR_WIDTH-1:0] int_vector;
    logic [1:0]            int_id;
    logic                  int_active;
    logic [NUM_IRQ-1:0]    irq_pending;
    logic [CNT_WIDTH-1:0]  instret;
    logic [4:0]            dut_st;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_stage_sequencer #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .NUM_IRQ         (NUM_IRQ),
        .IRQ_VECTOR_BASE (1),
        .CNT_WIDTH       (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_start   (mem_start),
        .mem_busy    (mem_busy),
        .reti        (reti),
        .irq         (irq),
        .fetch       (fetch),
        .get_regs    (get_regs),
        .read_mem    (read_mem),
        .write_back  (write_back),
        .int_take    (int_take),
        .int_vector  (int_vector),
        .int_id      (int_id),
        .int_active  (int_active),
        .irq_pending (irq_pending),
        .instret     (instret)
    );

    assign dut_st = {int_take, write_back, read_mem, get_regs, fetch};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stage index 0..4 = fetch, getRegs, readMem, writeBack, intTake.
    int          m_stage;
    bit          m_wait;
    bit          m_active;
    bit [3:0]    m_pend;
    int unsigned m_instret;
    bit [3:0]    m_hist[$];

    function automatic int lowest(input bit [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_stage   = 0;
        m_wait    = 1'b0;
        m_active  = 1'b0;
        m_pend    = '0;
        m_instret = 0;
        m_hist    = '{4'h0, 4'h0, 4'h0};
    endtask

    task automatic model_step(input bit ms, input bit mb, input bit rt, input bit [3:0] ir);
        bit [3:0] rise;
        int       nxt;
        // A line sampled high two edges ago after being low three edges ago latches now.
        rise = m_hist[m_hist.size() - 2] & ~m_hist[m_hist.size() - 3];
        nxt  = m_stage;
        case (m_stage)
            1: nxt = 2;
            4: begin
                m_pend[lowest(m_pend)] = 1'b0;
                m_active = 1'b1;
                nxt = 0;
            end
            default: begin
                if (!m_wait && ms) begin
                    m_wait = 1'b1;
                end else if (!m_wait || !mb) begin
                    m_wait = 1'b0;
                    if (m_stage == 3) begin
                        m_instret++;
                        if (rt) begin
                            m_active = 1'b0;
                            nxt = 0;
                        end else if (m_pend != 0 && !m_active) begin
                            nxt = 4;
                        end else begin
                            nxt = 0;
                        end
                    end else begin
                        nxt = m_stage + 1;
                    end
                end
            end
        endcase
        m_pend  = m_pend | rise;
        m_stage = nxt;
        m_hist.push_back(ir);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit ms, input bit mb, input bit rt, input bit [3:0] ir);
        mem_start = ms;
        mem_busy  = mb;
        reti      = rt;
        irq       = ir;
        model_step(ms, mb, rt, ir);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_chk(input bit ms, input bit mb, input bit rt, input bit [3:0] ir,
                            input bit [4:0] exp_st, input string name);
        cycle(ms, mb, rt, ir);
        check(name, dut_st, exp_st);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit          ms;
        bit          mb;
        bit          rt;
        bit [3:0]    ir;
        bit [4:0]    exp_st;
        int unsigned exp_instret;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input bit ms, input bit mb, input bit [4:0] st, input int unsigned ir_cnt);
        vec_t v;
        v.ms          = ms;
        v.mb          = mb;
        v.rt          = 1'b0;
        v.ir          = 4'h0;
        v.exp_st      = st;
        v.exp_instret = ir_cnt;
        vt.push_back(v);
    endtask

    initial begin
        bit [3:0] r_irq;

        for (int i = 0; i < 12; i++) begin
            add_vec(1'b0, 1'b0, 5'(ST_F << ((i + 1) % 4)), (i + 1) / 4);
        end
        // Fetch stall with three busy cycles; mem_start ignored while waiting and in getRegs.
        add_vec(1'b1, 1'b0, ST_F, 3);
        add_vec(1'b1, 1'b1, ST_F, 3);
        add_vec(1'b0, 1'b1, ST_F, 3);
        add_vec(1'b0, 1'b1, ST_F, 3);
        add_vec(1'b0, 1'b0, ST_G, 3);
        add_vec(1'b1, 1'b1, ST_R, 3);
        add_vec(1'b0, 1'b0, ST_W, 3);
        add_vec(1'b1, 1'b0, ST_W, 3);
        add_vec(1'b0, 1'b0, ST_F, 4);
        // readMem stall with one busy cycle.
        add_vec(1'b0, 1'b0, ST_G, 4);
        add_vec(1'b0, 1'b0, ST_R, 4);
        add_vec(1'b1, 1'b0, ST_R, 4);
        add_vec(1'b0, 1'b1, ST_R, 4);
        add_vec(1'b0, 1'b0, ST_W, 4);
        add_vec(1'b0, 1'b0, ST_F, 5);

        mem_start = 1'b0;
        mem_busy  = 1'b0;
        reti      = 1'b0;
        irq       = '0;
        reset     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_strobes", dut_st, ST_F);
        check("reset_instret", instret, 0);
        check("reset_pending", irq_pending, 0);
        check("reset_active", int_active, 0);
        reset = 1'b1;

        foreach (vt[k]) begin
            cycle(vt[k].ms, vt[k].mb, vt[k].rt, vt[k].ir);
            check($sformatf("vec%0d_strobes", k), dut_st, vt[k].exp_st);
            check($sformatf("vec%0d_instret", k), instret, vt[k].exp_instret);
        end

        // irq 0110 rises during readMem; writeBack is stretched until it is latched.
        step_chk(0, 0, 0, 4'h0, ST_G, "irq_g");
        step_chk(0, 0, 0, 4'h0, ST_R, "irq_r");
        step_chk(0, 0, 0, 4'h6, ST_W, "irq_w");
        step_chk(1, 0, 0, 4'h6, ST_W, "irq_w_issue");
        step_chk(0, 1, 0, 4'h6, ST_W, "irq_w_busy");
        check("irq_latched", irq_pending, 4'h6);
        step_chk(0, 0, 0, 4'h6, ST_I, "irq_take1");
        check("take1_id", int_id, 1);
        check("take1_vector", int_vector, 2);
        check("take1_instret", instret, 6);
        step_chk(0, 0, 0, 4'h6, ST_F, "take1_after");
        check("take1_pending", irq_pending, 4'h4);
        check("take1_active", int_active, 1);

        // Handler body: bit 2 stays pending while the handler runs.
        step_chk(0, 0, 0, 4'h6, ST_G, "hnd_g");
        step_chk(0, 0, 0, 4'h6, ST_R, "hnd_r");
        step_chk(0, 0, 0, 4'h6, ST_W, "hnd_w");
        step_chk(0, 0, 0, 4'h6, ST_F, "hnd_no_nest");
        check("hnd_instret", instret, 7);

        // RETI boundary: no interrupt check, handler flag drops.
        step_chk(0, 0, 0, 4'h6, ST_G, "reti_g");
        step_chk(0, 0, 1, 4'h6, ST_R, "reti_r");
        step_chk(0, 0, 1, 4'h6, ST_W, "reti_w");
        step_chk(0, 0, 1, 4'h6, ST_F, "reti_to_fetch");
        check("reti_active", int_active, 0);
        check("reti_pending", irq_pending, 4'h4);
        check("reti_instret", instret, 8);

        step_chk(0, 0, 0, 4'h6, ST_G, "take2_g");
        step_chk(0, 0, 0, 4'h6, ST_R, "take2_r");
        step_chk(0, 0, 0, 4'h6, ST_W, "take2_w");
        step_chk(0, 0, 0, 4'h6, ST_I, "take2");
        check("take2_id", int_id, 2);
        check("take2_vector", int_vector, 3);
        step_chk(0, 0, 0, 4'h0, ST_F, "take2_after");
        check("take2_pending", irq_pending, 0);

        step_chk(0, 0, 0, 4'h0, ST_G, "reti2_g");
        step_chk(0, 0, 1, 4'h0, ST_R, "reti2_r");
        step_chk(0, 0, 1, 4'h0, ST_W, "reti2_w");
        step_chk(0, 0, 1, 4'h0, ST_F, "reti2_f");
        check("reti2_active", int_active, 0);
        check("reti2_instret", instret, 10);

        // Second rise of irq[0] latches on the very edge that services bit 0.
        step_chk(0, 0, 0, 4'h1, ST_G, "sw_g");
        step_chk(0, 0, 0, 4'h0, ST_R, "sw_r");
        step_chk(0, 0, 0, 4'h1, ST_W, "sw_w");
        step_chk(0, 0, 0, 4'h1, ST_I, "sw_take");
        check("sw_id", int_id, 0);
        check("sw_vector", int_vector, 1);
        step_chk(0, 0, 0, 4'h1, ST_F, "sw_after");
        check("sw_pending_kept", irq_pending, 4'h1);
        check("sw_active", int_active, 1);

        // Reset while stalled in readMem abandons the access.
        step_chk(0, 0, 0, 4'h0, ST_G, "rst_g");
        step_chk(0, 0, 0, 4'h0, ST_R, "rst_r");
        step_chk(1, 0, 0, 4'h0, ST_R, "rst_issue");
        step_chk(0, 1, 0, 4'h0, ST_R, "rst_stall");
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_strobes", dut_st, ST_F);
        check("midrst_instret", instret, 0);
        check("midrst_pending", irq_pending, 0);
        check("midrst_active", int_active, 0);
        @(negedge clk);
        reset = 1'b1;
        check("postrst_strobes", dut_st, ST_F);
        step_chk(0, 1, 0, 4'h0, ST_G, "postrst_no_wait");

        // Random traffic against the model.
        r_irq = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) r_irq[$urandom_range(0, 3)] = ~r_irq[$urandom_range(0, 3)];
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, r_irq);
            check("rnd_strobes", dut_st, 5'(ST_F << m_stage));
            check("rnd_instret", instret, m_instret);
            check("rnd_pending", irq_pending, m_pend);
            check("rnd_active", int_active, m_active);
            if (m_stage == 4) begin
                check("rnd_id", int_id, lowest(m_pend));
                check("rnd_vector", int_vector, 1 + lowest(m_pend));
            end
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
                check("rnd_reset", dut_st, ST_F);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
